// File: rtl/debounce_pkg.sv
// debounce_pkg: shared channel state type and counter width helper
package debounce_pkg;
  typedef enum logic [1:0] {DB_LOW, DB_WAIT_HI, DB_HIGH, DB_WAIT_LO} db_state_t;
  function automatic int cnt_width(int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchroniser + qualification FSM + counter + edge pulses
// clk/reset_n: clock, async active-low reset; tick: count enable; noisy: raw pin
// debounced: clean level; rise/fall: one-cycle pulses on level change
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic noisy,
  output logic debounced,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  db_state_t r_state, w_state;
  logic r_deb, r_rise, r_fall;
  logic w_s, w_done, w_hi;
  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_done = tick && (r_cnt == CMAX);
  // level follows the state being entered, so level and pulses update on the same edge
  assign w_hi = (w_state == DB_HIGH) || (w_state == DB_WAIT_LO);
  assign debounced = r_deb;
  assign rise = r_rise;
  assign fall = r_fall;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    case (r_state)
      DB_LOW: if (w_s) begin
        w_state = DB_WAIT_HI;
        w_cnt = CW'(tick);
      end
      DB_WAIT_HI: if (!w_s) begin
        w_state = DB_LOW;
        w_cnt = '0;
      end else if (tick) begin
        w_state = w_done ? DB_HIGH : DB_WAIT_HI;
        w_cnt = w_done ? '0 : r_cnt + 1'b1;
      end
      DB_HIGH: if (!w_s) begin
        w_state = DB_WAIT_LO;
        w_cnt = CW'(tick);
      end
      DB_WAIT_LO: if (w_s) begin
        w_state = DB_HIGH;
        w_cnt = '0;
      end else if (tick) begin
        w_state = w_done ? DB_LOW : DB_WAIT_LO;
        w_cnt = w_done ? '0 : r_cnt + 1'b1;
      end
      default: begin
        w_state = DB_LOW;
        w_cnt = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_state <= DB_LOW;
      r_cnt <= '0;
      r_deb <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], noisy};
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_deb <= w_hi;
      r_rise <= w_hi & ~r_deb;
      r_fall <= ~w_hi & r_deb;
    end
  end
endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: NUM_CH independent debouncers sharing clock, reset and tick
// clk/reset_n: clock, async active-low reset; tick: shared count enable
// noisy: raw pins; debounced: clean levels; rise/fall: per-channel edge pulses
module debounce_multi #(
  parameter int NUM_CH = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [NUM_CH-1:0] noisy,
  output logic [NUM_CH-1:0] debounced,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .tick(tick),
      .noisy(noisy[i]),
      .debounced(debounced[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed scoreboard bench for debounce_multi
module tb_debounce_multi;
  localparam int SC = 4;
  localparam int SS = 2;
  localparam int LAT = SS - 1 + SC;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b1;
  logic [3:0] noisy = 4'b0;
  logic [3:0] debounced, rise, fall;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int k;
  typedef struct {
    int due;
    string tag;
    logic [11:0] e;
    logic [11:0] m;
  } exp_t;
  exp_t q[$];
  debounce_multi #(.NUM_CH(4), .STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick),
    .noisy(noisy),
    .debounced(debounced),
    .rise(rise),
    .fall(fall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        total++;
        assert (({debounced, rise, fall} & q[i].m) === q[i].e)
        else begin
          bad++;
          $error("FAIL %s cyc=%0d got=%h exp=%h", q[i].tag, cyc, {debounced, rise, fall} & q[i].m, q[i].e);
        end
        q.delete(i);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_at(input int due, input string tag, input logic [3:0] d, r, f, chm);
    exp_t x;
    x.due = due;
    x.tag = tag;
    x.m = {chm, chm, chm};
    x.e = {d, r, f} & x.m;
    q.push_back(x);
  endtask
  task automatic expect_span(input int a, b, input string tag, input logic [3:0] d, r, f, chm);
    for (int c = a; c <= b; c++) expect_at(c, tag, d, r, f, chm);
  endtask
  task automatic check_now(input string tag, input logic [11:0] e);
    total++;
    assert ({debounced, rise, fall} === e)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, {debounced, rise, fall}, e);
    end
  endtask
  task automatic edge_check(input string tag, input logic [3:0] pre, post, r, f, chm);
    expect_span(k + 1, k + LAT, {tag, "_wait"}, pre, 4'b0, 4'b0, chm);
    expect_at(k + LAT + 1, {tag, "_edge"}, post, r, f, chm);
    expect_at(k + LAT + 2, {tag, "_after"}, post, 4'b0, 4'b0, chm);
  endtask
  logic pat [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  initial begin
    step(2);
    check_now("reset", 12'h000);
    reset_n = 1'b1;
    step(2);
    k = cyc;
    noisy = 4'b0001;
    edge_check("press", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1111);
    step(LAT + 3);
    k = cyc;
    noisy = 4'b0000;
    edge_check("release", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1111);
    step(LAT + 3);
    k = cyc;
    expect_span(k + 1, k + 10 + LAT, "bounce_quiet", 4'b0, 4'b0, 4'b0, 4'b0010);
    expect_at(k + 11 + LAT, "bounce_rise", 4'b0010, 4'b0010, 4'b0, 4'b0010);
    expect_at(k + 12 + LAT, "bounce_after", 4'b0010, 4'b0, 4'b0, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      noisy[1] = pat[i];
      step(1);
    end
    noisy[1] = 1'b1;
    step(LAT + 3);
    k = cyc;
    noisy[1] = 1'b0;
    edge_check("bounce_rel", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
    step(LAT + 3);
    k = cyc;
    noisy[2] = 1'b1;
    tick = 1'b0;
    expect_span(k + 1, k + 11, "tick_quiet", 4'b0, 4'b0, 4'b0, 4'b0100);
    expect_at(k + 12, "tick_rise", 4'b0100, 4'b0100, 4'b0, 4'b0100);
    expect_at(k + 13, "tick_after", 4'b0100, 4'b0, 4'b0, 4'b0100);
    for (int i = 1; i <= 14; i++) begin
      step(1);
      tick = (i % 3 == 2);
    end
    tick = 1'b1;
    step(1);
    k = cyc;
    noisy[2] = 1'b0;
    edge_check("tick_rel", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    step(LAT + 3);
    k = cyc;
    noisy[2] = 1'b1;
    tick = 1'b0;
    expect_span(k + 1, k + 17, "glitch_quiet", 4'b0, 4'b0, 4'b0, 4'b0100);
    expect_at(k + 18, "glitch_rise", 4'b0100, 4'b0100, 4'b0, 4'b0100);
    expect_at(k + 19, "glitch_after", 4'b0100, 4'b0, 4'b0, 4'b0100);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      tick = (i % 3 == 2);
      if (i == 4) noisy[2] = 1'b0;
      if (i == 5) noisy[2] = 1'b1;
    end
    tick = 1'b1;
    k = cyc;
    noisy[2] = 1'b0;
    edge_check("glitch_rel", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    step(LAT + 3);
    k = cyc;
    noisy[0] = 1'b1;
    edge_check("pre_reset", 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    step(LAT + 3);
    noisy[3] = 1'b1;
    step(3);
    #2;
    reset_n = 1'b0;
    #1;
    check_now("async_reset", 12'h000);
    step(2);
    check_now("reset_hold", 12'h000);
    reset_n = 1'b1;
    k = cyc;
    edge_check("post_reset", 4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b1111);
    step(LAT + 3);
    k = cyc;
    noisy = 4'b0000;
    edge_check("drop", 4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b1111);
    step(LAT + 3);
    k = cyc;
    noisy = 4'b1111;
    edge_check("simul_rise", 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
    step(LAT + 3);
    k = cyc;
    noisy = 4'b0000;
    edge_check("simul_fall", 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111);
    step(LAT + 3);
    total++;
    assert (q.size() == 0)
    else begin
      bad++;
      $error("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
